// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM encoding,
// frame length and elaboration-time helpers for the baud divider and widths.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      SEND  = 2'd2
   } arb_state_t;

   localparam int FRAME_BITS = 10;

   function automatic int baud_div(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

   function automatic int clog2(input int value);
      int v;
      int r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer, LSB first. A start pulse while idle loads one frame; done_o
// pulses in the last cycle of the stop bit so the owner FSM can move on in step.
module uart_tx_serializer
   import uart_arb_pkg::*;
#(
   parameter int BAUD_DIV = 5208
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       txd_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam int CW = (clog2(BAUD_DIV) > 0) ? clog2(BAUD_DIV) : 1;

   logic [CW-1:0]         baud_cnt;
   logic [3:0]            bit_cnt;
   logic [FRAME_BITS-1:0] frame;
   logic                  bit_end;
   logic                  last_bit;

   assign bit_end  = busy_o && (baud_cnt == CW'(BAUD_DIV - 1));
   assign last_bit = (bit_cnt == 4'(FRAME_BITS - 1));
   assign done_o   = bit_end && last_bit;
   // The shift register refills with ones, so the line idles high between frames.
   assign txd_o    = frame[0];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         frame    <= '1;
         busy_o   <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else if (start_i && !busy_o) begin
         frame    <= {1'b1, data_i, 1'b0};
         busy_o   <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else if (busy_o) begin
         if (bit_end) begin
            baud_cnt <= '0;
            frame    <= {1'b1, frame[FRAME_BITS-1:1]};
            if (last_bit) begin
               busy_o  <= 1'b0;
               bit_cnt <= '0;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else begin
            baud_cnt <= baud_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one UART TX line among NUM_REQ
// byte-stream requesters. Ownership ends on a byte flagged last or after an idle timeout.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int CLOCK_FREQ   = 100000000,
   parameter int BAUD_RATE    = 19200,
   parameter int IDLE_TIMEOUT = 65536
) (
   input  logic                                  clk_i,
   input  logic                                  rstn_i,
   input  logic [NUM_REQ-1:0]                    req_valid_i,
   input  logic [8*NUM_REQ-1:0]                  req_data_i,
   input  logic [NUM_REQ-1:0]                    req_last_i,
   output logic [NUM_REQ-1:0]                    req_ready_o,
   output logic                                  uart_txd_o,
   output logic [((NUM_REQ > 1) ? clog2(NUM_REQ) : 1)-1:0] grant_o,
   output logic                                  grant_valid_o,
   output logic                                  busy_o,
   output logic [1:0]                            state_o
);

   localparam int GW = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
   localparam int BD = baud_div(CLOCK_FREQ, BAUD_RATE);
   localparam int TW = (clog2(IDLE_TIMEOUT + 1) > 0) ? clog2(IDLE_TIMEOUT + 1) : 1;

   arb_state_t    state, state_nxt;
   logic [GW-1:0] last_owner;
   logic [GW-1:0] pick;
   logic          pick_found;
   int            rr_idx;
   logic [TW-1:0] idle_cnt;
   logic          last_q;
   logic          accept;
   logic          timeout;
   logic          ser_done;

   // Handshake: a byte transfers in any cycle where the owner's req_valid_i and
   // req_ready_o[grant_o] are both high; valid/data/last must hold until then.
   assign accept  = (state == GRANT) && req_valid_i[grant_o];
   assign timeout = (idle_cnt == TW'(IDLE_TIMEOUT - 1));
   assign state_o = state;

   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      rr_idx     = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         rr_idx = (int'(last_owner) + i) % NUM_REQ;
         if (!pick_found && req_valid_i[rr_idx]) begin
            pick       = GW'(rr_idx);
            pick_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (pick_found) state_nxt = GRANT;
         GRANT:   if (accept) state_nxt = SEND;
                  else if (timeout) state_nxt = IDLE;
         SEND:    if (ser_done) state_nxt = last_q ? IDLE : GRANT;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = '0;
      if (state == GRANT) req_ready_o[grant_o] = 1'b1;
      grant_valid_o = (state != IDLE);
   end

   // The idle counter only advances in GRANT, so time spent in SEND never counts.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         grant_o    <= '0;
         last_owner <= GW'(NUM_REQ - 1);
         idle_cnt   <= '0;
         last_q     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (pick_found) grant_o <= pick;
            GRANT: begin
               if (accept) begin
                  last_q   <= req_last_i[grant_o];
                  idle_cnt <= '0;
               end else if (timeout) begin
                  idle_cnt   <= '0;
                  last_owner <= grant_o;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            SEND: if (ser_done && last_q) last_owner <= grant_o;
            default: ;
         endcase
      end
   end

   uart_tx_serializer #(.BAUD_DIV(BD)) u_ser (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .start_i(accept),
      .data_i (req_data_i[8*grant_o +: 8]),
      .txd_o  (uart_txd_o),
      .busy_o (busy_o),
      .done_o (ser_done)
   );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios against a message-level model,
// a line receiver feeding a byte scoreboard, and hand-computed timing checks.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ      = 4;
   localparam int CLOCK_FREQ   = 1000000;
   localparam int BAUD_RATE    = 100000;
   localparam int IDLE_TIMEOUT = 50;
   localparam int BD           = 10;
   localparam int FRAME_CYC    = 10 * BD;

   logic                   clk_i = 1'b0;
   logic                   rstn_i = 1'b0;
   logic [NUM_REQ-1:0]     req_valid_i;
   logic [8*NUM_REQ-1:0]   req_data_i;
   logic [NUM_REQ-1:0]     req_last_i;
   logic [NUM_REQ-1:0]     req_ready_o;
   logic                   uart_txd_o;
   logic [1:0]             grant_o;
   logic                   grant_valid_o;
   logic                   busy_o;
   logic [1:0]             state_o;

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ), .CLOCK_FREQ(CLOCK_FREQ),
      .BAUD_RATE(BAUD_RATE), .IDLE_TIMEOUT(IDLE_TIMEOUT)
   ) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .req_valid_i(req_valid_i),
      .req_data_i(req_data_i), .req_last_i(req_last_i), .req_ready_o(req_ready_o),
      .uart_txd_o(uart_txd_o), .grant_o(grant_o), .grant_valid_o(grant_valid_o),
      .busy_o(busy_o), .state_o(state_o)
   );

   initial forever #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   logic [8:0]         src_q[NUM_REQ][$];
   logic [NUM_REQ-1:0] took = '0;
   bit                 rand_mode = 0;

   task automatic tick();
      @(negedge clk_i);
      if (!rstn_i) took = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (took[k]) begin
            if (rand_mode) req_valid_i[k] = 1'b0;
            else if (src_q[k].size() > 0) void'(src_q[k].pop_front());
         end
         if (rand_mode) begin
            if (!req_valid_i[k]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req_valid_i[k]        = 1'b1;
                  req_data_i[8*k +: 8]  = 8'($urandom_range(0, 255));
                  req_last_i[k]         = 1'($urandom_range(0, 1));
               end
            end else if (!took[k] && $urandom_range(0, 49) == 0) begin
               req_valid_i[k] = 1'b0;
            end
         end else begin
            req_valid_i[k] = (src_q[k].size() > 0);
            if (src_q[k].size() > 0) {req_last_i[k], req_data_i[8*k +: 8]} = src_q[k][0];
         end
      end
      took = req_valid_i & req_ready_o;
   endtask

   function automatic bit srcs_empty();
      for (int k = 0; k < NUM_REQ; k++) if (src_q[k].size() > 0) return 0;
      return 1;
   endfunction

   task automatic wait_quiet(input string name, input int budget);
      int n;
      n = 0;
      while (!(srcs_empty() && !grant_valid_o && !busy_o) && n < budget) begin
         tick();
         n++;
      end
      check(name, n < budget, 1);
   endtask

   // ---------------- model and scoreboard ----------------
   int         m_owner, m_last, m_ft, m_quiet;
   logic [7:0] m_byte;
   logic       m_end;
   logic [7:0] exp_q[$];
   logic [7:0] rx_log[$];
   int         grant_log[$];
   bit         rx_active = 0;
   int         rx_t = 0;
   logic [7:0] rx_byte;
   logic       prev_gv = 1'b0;

   task automatic model_step();
      bit found;
      int k;
      if (!rstn_i) begin
         m_owner = -1; m_last = NUM_REQ - 1; m_ft = -1; m_quiet = 0;
         exp_q.delete();
      end else if (m_owner < 0) begin
         found = 0;
         for (int i = 1; i <= NUM_REQ; i++) begin
            k = (m_last + i) % NUM_REQ;
            if (!found && req_valid_i[k]) begin
               m_owner = k;
               found = 1;
            end
         end
      end else if (m_ft >= 0) begin
         m_ft++;
         if (m_ft == FRAME_CYC) begin
            m_ft = -1;
            if (m_end) begin m_last = m_owner; m_owner = -1; end
         end
      end else if (req_valid_i[m_owner]) begin
         m_byte = req_data_i[8*m_owner +: 8];
         m_end  = req_last_i[m_owner];
         m_ft = 0; m_quiet = 0;
         exp_q.push_back(m_byte);
      end else begin
         m_quiet++;
         if (m_quiet == IDLE_TIMEOUT) begin
            m_quiet = 0; m_last = m_owner; m_owner = -1;
         end
      end
   endtask

   task automatic compare_step();
      int         idx;
      int         bitn;
      logic       exp_txd;
      logic [3:0] exp_ready;
      exp_ready = (m_owner >= 0 && m_ft < 0) ? (4'b0001 << m_owner) : 4'b0000;
      exp_txd = 1'b1;
      if (m_ft >= 0) begin
         idx = m_ft / BD;
         exp_txd = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : m_byte[idx-1];
      end
      check("ready", req_ready_o, exp_ready);
      check("grant_valid", grant_valid_o, m_owner >= 0);
      check("busy", busy_o, m_ft >= 0);
      check("txd", uart_txd_o, exp_txd);
      if (m_owner >= 0) check("grant", grant_o, m_owner);
      check("ready_onehot", $countones(req_ready_o) <= 1, 1);
      check("ready_while_busy", busy_o ? req_ready_o : 4'b0000, 0);
      if (grant_valid_o && !prev_gv) grant_log.push_back(int'(grant_o));
      prev_gv = grant_valid_o;
      if (!rstn_i) begin
         rx_active = 0;
      end else if (rx_active) begin
         rx_t++;
         if (rx_t % BD == BD / 2) begin
            bitn = rx_t / BD;
            if (bitn >= 1 && bitn <= 8) rx_byte[bitn-1] = uart_txd_o;
            else if (bitn == 9) begin
               rx_active = 0;
               check("rx_stop", uart_txd_o, 1);
               rx_log.push_back(rx_byte);
               check("rx_expected_any", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) check("rx_byte", rx_byte, exp_q.pop_front());
            end
         end
      end else if (uart_txd_o == 1'b0) begin
         rx_active = 1;
         rx_t = 0;
      end
   endtask

   initial begin
      m_owner = -1; m_last = NUM_REQ - 1; m_ft = -1; m_quiet = 0;
      forever begin
         @(posedge clk_i);
         model_step();
         #2;
         compare_step();
      end
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int         n;
      logic [7:0] msg2[4] = '{8'h4E, 8'h45, 8'h4F, 8'h52};
      int         order3[5] = '{0, 1, 2, 3, 0};

      req_valid_i = '0; req_data_i = '0; req_last_i = '0;
      tick(); tick();
      check("rst_txd", uart_txd_o, 1);
      check("rst_ready", req_ready_o, 0);
      check("rst_grant", grant_o, 0);
      check("rst_grant_valid", grant_valid_o, 0);
      check("rst_busy", busy_o, 0);
      rstn_i = 1'b1;
      tick();

      // Single byte from requester 2
      src_q[2].push_back({1'b1, 8'h4E});
      tick();
      check("t1_gv_before", grant_valid_o, 0);
      tick();
      check("t1_gv", grant_valid_o, 1);
      check("t1_grant", grant_o, 2);
      check("t1_ready", req_ready_o, 4'b0100);
      tick();
      check("t1_busy_start", busy_o, 1);
      check("t1_txd_start", uart_txd_o, 0);
      n = 0;
      while (busy_o && n < 200) begin n++; tick(); end
      check("t1_busy_cycles", n, 100);
      check("t1_idle_after", grant_valid_o, 0);
      check("t1_rx_count", rx_log.size(), 1);
      if (rx_log.size() > 0) check("t1_rx", rx_log.pop_front(), 8'h4E);

      // Message ownership: "NEO" from 0 is not interleaved with 'R' from 1
      rx_log.delete();
      src_q[0].push_back({1'b0, 8'h4E});
      src_q[0].push_back({1'b0, 8'h45});
      src_q[0].push_back({1'b1, 8'h4F});
      src_q[1].push_back({1'b1, 8'h52});
      wait_quiet("t2_wait", 2000);
      check("t2_rx_count", rx_log.size(), 4);
      for (int i = 0; i < 4; i++) if (i < rx_log.size()) check("t2_rx_seq", rx_log[i], msg2[i]);

      // Round-robin after reset
      tick(); rstn_i = 1'b0; tick(); tick(); rstn_i = 1'b1;
      rx_log.delete(); grant_log.delete();
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < NUM_REQ; k++) src_q[k].push_back({1'b1, 8'(8'hA0 + k)});
      wait_quiet("t3_wait", 3000);
      check("t3_grant_count", grant_log.size() >= 5, 1);
      for (int i = 0; i < 5; i++) begin
         if (i < grant_log.size()) check("t3_grant_order", grant_log[i], order3[i]);
         if (i < rx_log.size()) check("t3_rx_order", rx_log[i], 8'hA0 + order3[i]);
      end

      // Idle timeout from requester 3, then waiting requester 0 takes over
      src_q[3].push_back({1'b0, 8'h41});
      n = 0;
      while (!(grant_valid_o && grant_o == 2'd3) && n < 20) begin tick(); n++; end
      check("t4_grant3", n < 20, 1);
      src_q[0].push_back({1'b1, 8'h5A});
      n = 0;
      while (!busy_o && n < 20) begin tick(); n++; end
      check("t4_busy_rise", n < 20, 1);
      n = 0;
      while (busy_o && n < 200) begin tick(); n++; end
      check("t4_busy_fall", n < 200, 1);
      n = 0;
      while (grant_valid_o && n < 200) begin n++; tick(); end
      check("t4_hold_cycles", n, 50);
      tick();
      check("t4_next_gv", grant_valid_o, 1);
      check("t4_next_grant", grant_o, 0);
      wait_quiet("t4_wait", 500);

      // Reset 30 cycles into a frame
      src_q[2].push_back({1'b1, 8'h33});
      n = 0;
      while (!busy_o && n < 20) begin tick(); n++; end
      check("t5_busy_rise", n < 20, 1);
      repeat (29) tick();
      check("t5_mid_frame", busy_o, 1);
      rstn_i = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) src_q[k].delete();
      req_valid_i = '0;
      #1;
      check("t5_txd", uart_txd_o, 1);
      check("t5_gv", grant_valid_o, 0);
      check("t5_busy", busy_o, 0);
      check("t5_ready", req_ready_o, 0);
      tick(); tick();
      rstn_i = 1'b1;
      grant_log.delete();
      src_q[0].push_back({1'b1, 8'h61});
      src_q[3].push_back({1'b1, 8'h64});
      n = 0;
      while (grant_log.size() == 0 && n < 20) begin tick(); n++; end
      check("t5_regrant", grant_log.size() > 0, 1);
      if (grant_log.size() > 0) check("t5_first_winner", grant_log[0], 0);
      wait_quiet("t5_wait", 500);

      // Random valid patterns
      rand_mode = 1;
      repeat (10000) tick();
      rand_mode = 0;
      req_valid_i = '0;
      wait_quiet("t6_wait", 500);
      repeat (5) tick();
      check("t6_drain", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
